// File: rtl/led_bank_ctrl.sv
// Bus-mapped LED bank: DATA/MODE/PERIOD(/BRIGHT) registers, blink engine, registered LED drive.
// Optional PWM brightness register and counter are built when LED_PWM_EN is defined.
module led_bank_ctrl #(
  parameter int         NUM_LEDS  = 16,
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter int         TICK_DIV  = 100000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [7:0]          BUS_ADDR,
  inout  wire  [7:0]          BUS_DATA,
  input  logic                BUS_WE,
  output logic [NUM_LEDS-1:0] LEDS
);

  localparam int NB = NUM_LEDS / 8;
`ifdef LED_PWM_EN
  localparam int WIN = NB + 3;
  localparam logic [7:0] OFF_BRIGHT = 8'(NB + 2);
`else
  localparam int WIN = NB + 2;
`endif
  localparam logic [7:0] WIN_SZ     = 8'(WIN);
  localparam logic [7:0] OFF_MODE   = 8'(NB);
  localparam logic [7:0] OFF_PERIOD = 8'(NB + 1);
  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  // Register state
  logic [NUM_LEDS-1:0] data_q, data_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          period_q, period_d;
  logic [PS_W-1:0]     prescale_q, prescale_d;
  logic [7:0]          blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
`ifdef LED_PWM_EN
  logic [7:0]          bright_q, bright_d;
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
`endif

  // Address decode; the 9-bit subtraction keeps addresses below BASE_ADDR out of the window
  logic [8:0] off_full;
  logic [7:0] offset;
  logic       hit;
  logic       wr_en;
  logic       rd_en;
  logic       cfg_wr;
  logic       tick;
  logic       pwm_on;
  logic [7:0] rd_data;

  assign off_full = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign offset   = off_full[7:0];
  assign hit      = ~off_full[8] && (offset < WIN_SZ);
  assign wr_en    = hit && BUS_WE;
  assign rd_en    = hit && !BUS_WE;
  assign cfg_wr   = wr_en && ((offset == OFF_MODE) || (offset == OFF_PERIOD));
  assign tick     = (prescale_q == PS_MAX);

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (offset == 8'(i)) rd_data = data_q[8*i +: 8];
    end
    if (offset == OFF_MODE)   rd_data = {6'b0, mode_q};
    if (offset == OFF_PERIOD) rd_data = period_q;
`ifdef LED_PWM_EN
    if (offset == OFF_BRIGHT) rd_data = bright_q;
`endif
  end

  assign BUS_DATA = rd_en ? rd_data : 8'hzz;

  // Register writes
  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    for (int i = 0; i < NB; i++) begin
      if (wr_en && (offset == 8'(i))) data_d[8*i +: 8] = BUS_DATA;
    end
    if (wr_en && (offset == OFF_MODE))   mode_d   = BUS_DATA[1:0];
    if (wr_en && (offset == OFF_PERIOD)) period_d = BUS_DATA;
  end

`ifdef LED_PWM_EN
  always_comb begin
    bright_d  = bright_q;
    if (wr_en && (offset == OFF_BRIGHT)) bright_d = BUS_DATA;
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end
  assign pwm_on = (bright_q == 8'hFF) || (pwm_cnt_q < bright_q);
`else
  assign pwm_on = 1'b1;
`endif

  // Blink engine: a config write restarts the count from zero, and wins over a coincident tick
  always_comb begin
    prescale_d  = (cfg_wr || tick) ? '0 : prescale_q + 1'b1;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (cfg_wr || !mode_q[0] || (period_q == 8'd0)) begin
      blink_cnt_d = 8'd0;
      phase_d     = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == period_q - 8'd1) begin
        blink_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Invert before gating so a dark phase is always fully dark
  assign leds_d = (data_q ^ {NUM_LEDS{mode_q[1]}}) & {NUM_LEDS{phase_q & pwm_on}};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q      <= '0;
      mode_q      <= 2'b00;
      period_q    <= 8'd0;
      prescale_q  <= '0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b1;
      leds_q      <= '0;
`ifdef LED_PWM_EN
      bright_q    <= 8'hFF;
      pwm_cnt_q   <= 8'd0;
`endif
    end else begin
      data_q      <= data_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      prescale_q  <= prescale_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      leds_q      <= leds_d;
`ifdef LED_PWM_EN
      bright_q    <= bright_d;
      pwm_cnt_q   <= pwm_cnt_d;
`endif
    end
  end

  assign LEDS = leds_q;

endmodule
